traffic_phase_sequencer: RTL and testbench



---
 rtl/traffic_phase_sequencer_if.sv | 14 +
 rtl/traffic_phase_sequencer.sv | 125 ++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_sequencer_if.sv
// Run-time timing-table write port of the traffic phase sequencer.
// The host side drives it as master and the sequencer samples it as slave.
interface traffic_phase_sequencer_if #(
    parameter int TW = 8,
    parameter int PW = 3
);
    logic          cfg_we;
    logic [1:0]    cfg_table;
    logic [PW-1:0] cfg_phase;
    logic [TW-1:0] cfg_time;

    modport master (output cfg_we, cfg_table, cfg_phase, cfg_time);
    modport slave  (input  cfg_we, cfg_table, cfg_phase, cfg_time);
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Multi-phase traffic-signal sequencer: per-mode timing tables, sensor-driven
// phase jumps, latched pedestrian grants and green-change pulses.
module traffic_phase_sequencer #(
    parameter int TICK_DIV    = 48_000_000,
    parameter int N_PHASES    = 5,
    parameter int N_LIGHTS    = 3,
    parameter int TW          = 8,
    parameter int PW          = 3,
    parameter int DEFAULT_SEC = 1,
    parameter logic [N_PHASES*N_LIGHTS-1:0] PHASE_GREEN = 15'b011_001_100_010_001,
    parameter logic [N_LIGHTS*PW-1:0]       SENS_PHASE  = 9'b011_100_010
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [N_LIGHTS-1:0]       SENS,
    input  logic [N_LIGHTS-1:0]       PUSH,
    traffic_phase_sequencer_if.slave  cfg,
    output logic [PW-1:0]             PHASE,
    output logic [1:0]                TABLE,
    output logic [N_LIGHTS-1:0]       GREEN,
    output logic [N_LIGHTS-1:0]       CS,
    output logic [N_LIGHTS-1:0]       CG
);
    localparam int N_TABLES = N_LIGHTS + 1;
    localparam int CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // A zero duration would never reach the boundary, so it runs as one second.
    function automatic logic [TW-1:0] sat_dur(input logic [TW-1:0] d);
        return (d == '0) ? TW'(1) : d;
    endfunction

    logic [N_LIGHTS-1:0] sens_p0, sens_p1, push_p0, push_p1;
    logic [CW-1:0]       cnt;
    logic                tick;
    logic [TW-1:0]       tim [N_TABLES][N_PHASES];
    logic [TW-1:0]       remain;
    logic [N_LIGHTS-1:0] req;
    logic [PW-1:0]       nxt_phase;
    logic [1:0]          nxt_table;
    logic [N_LIGHTS-1:0] nxt_green;
    logic [N_LIGHTS-1:0] grant;
    logic [PW-1:0]       tgt;

    // Stage p0/p1: two-flop synchronisers for the asynchronous board inputs
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sens_p0 <= '0;
            sens_p1 <= '0;
            push_p0 <= '0;
            push_p1 <= '0;
        end else begin
            sens_p0 <= SENS;
            sens_p1 <= sens_p0;
            push_p0 <= PUSH;
            push_p1 <= push_p0;
        end
    end

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= tick ? '0 : cnt + CW'(1);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < N_TABLES; t++)
                for (int p = 0; p < N_PHASES; p++)
                    tim[t][p] <= TW'(DEFAULT_SEC);
        end else if (cfg.cfg_we && int'(cfg.cfg_table) <= N_LIGHTS
                     && int'(cfg.cfg_phase) < N_PHASES) begin
            tim[cfg.cfg_table][cfg.cfg_phase] <= cfg.cfg_time;
        end
    end

    always_comb begin
        nxt_phase = (PHASE == PW'(N_PHASES - 1)) ? '0 : PHASE + PW'(1);
        nxt_table = 2'd0;
        tgt       = '0;
        if ($onehot(sens_p1)) begin
            for (int k = 0; k < N_LIGHTS; k++) begin
                if (sens_p1[k]) begin
                    tgt = SENS_PHASE[k*PW +: PW];
                    if (int'(tgt) < N_PHASES && tgt != PHASE) begin
                        nxt_phase = tgt;
                        nxt_table = 2'(k + 1);
                    end
                end
            end
        end
        nxt_green = PHASE_GREEN[int'(nxt_phase)*N_LIGHTS +: N_LIGHTS];
        grant     = req & nxt_green;
    end

    // Phase entry: every output and the countdown update on the edge that ends the boundary cycle
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            PHASE  <= '0;
            TABLE  <= 2'd0;
            GREEN  <= PHASE_GREEN[N_LIGHTS-1:0];
            CS     <= '0;
            CG     <= '0;
            remain <= sat_dur(TW'(DEFAULT_SEC));
            req    <= '0;
        end else begin
            CS  <= '0;
            CG  <= '0;
            req <= req | push_p1;
            if (tick) begin
                if (remain == TW'(1)) begin
                    PHASE  <= nxt_phase;
                    TABLE  <= nxt_table;
                    GREEN  <= nxt_green;
                    CS     <= GREEN ^ nxt_green;
                    CG     <= grant;
                    req    <= (req | push_p1) & ~grant;
                    remain <= sat_dur(tim[nxt_table][nxt_phase]);
                end else begin
                    remain <= remain - TW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with a four-cycle tick.
module tb_traffic_phase_sequencer;
    logic       CLK;
    logic       reset;
    logic [2:0] SENS, PUSH;
    logic [2:0] PHASE;
    logic [1:0] TABLE;
    logic [2:0] GREEN, CS, CG;
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc;

    traffic_phase_sequencer_if #(.TW(8), .PW(3)) cfg_bus ();

    traffic_phase_sequencer #(.TICK_DIV(4)) dut (
        .CLK   (CLK),
        .reset (reset),
        .SENS  (SENS),
        .PUSH  (PUSH),
        .cfg   (cfg_bus),
        .PHASE (PHASE),
        .TABLE (TABLE),
        .GREEN (GREEN),
        .CS    (CS),
        .CG    (CG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Returns the number of cycles until PHASE changes; 100 means it never did.
    task automatic run_to_entry(output int c);
        logic [2:0] start;
        start = PHASE;
        c = 0;
        do begin
            step(1);
            c++;
        end while (PHASE == start && c < 100);
    endtask

    task automatic cfg_write(input logic [1:0] t, input logic [2:0] p, input logic [7:0] d);
        cfg_bus.cfg_we    = 1'b1;
        cfg_bus.cfg_table = t;
        cfg_bus.cfg_phase = p;
        cfg_bus.cfg_time  = d;
        step(1);
        cfg_bus.cfg_we    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        SENS = '0;
        PUSH = '0;
        cfg_bus.cfg_we = 1'b0;
        cfg_bus.cfg_table = '0;
        cfg_bus.cfg_phase = '0;
        cfg_bus.cfg_time = '0;
        #21;
        chk("rst_phase", PHASE, 0);
        chk("rst_table", TABLE, 0);
        chk("rst_green", GREEN, 3'b001);
        chk("rst_cs", CS, 0);
        chk("rst_cg", CG, 0);
        #1 reset = 1'b0;

        // Free run with default durations
        run_to_entry(cyc);
        chk("fr_len0", cyc, 4);
        chk("fr_ph1", PHASE, 1);
        chk("fr_cs01", CS, 3'b011);
        chk("fr_gr1", GREEN, 3'b010);
        chk("fr_tb1", TABLE, 0);
        chk("fr_cg1", CG, 0);
        step(1);
        chk("fr_cs_pulse", CS, 0);
        run_to_entry(cyc);
        chk("fr_len1", cyc, 3);
        chk("fr_ph2", PHASE, 2);

        // Config writes during phase 2: one valid, one out of range
        cfg_write(2'd0, 3'd0, 8'd3);
        cfg_write(2'd0, 3'd5, 8'd7);
        run_to_entry(cyc);
        chk("cfg_len2", cyc, 2);
        chk("fr_ph3", PHASE, 3);
        run_to_entry(cyc);
        chk("fr_len3", cyc, 4);
        chk("fr_ph4", PHASE, 4);
        run_to_entry(cyc);
        chk("fr_len4", cyc, 4);
        chk("fr_ph0", PHASE, 0);
        chk("fr_cs40", CS, 3'b010);
        chk("fr_gr0", GREEN, 3'b001);
        chk("fr_tb0", TABLE, 0);
        run_to_entry(cyc);
        chk("cfg_len0_12", cyc, 12);
        chk("cfg_ph1", PHASE, 1);

        // Two sensors at once: no jump
        SENS = 3'b011;
        cfg_write(2'd2, 3'd4, 8'd2);
        run_to_entry(cyc);
        chk("ms_len1", cyc, 3);
        chk("ms_ph2", PHASE, 2);
        chk("ms_tb0", TABLE, 0);
        SENS = 3'b000;
        run_to_entry(cyc);
        chk("seq_ph3", PHASE, 3);
        run_to_entry(cyc);
        chk("seq_ph4", PHASE, 4);
        run_to_entry(cyc);
        chk("seq_ph0", PHASE, 0);

        // Single sensor 1 jumps 0 -> 4 with table 2
        SENS = 3'b010;
        run_to_entry(cyc);
        chk("sj_len0", cyc, 12);
        chk("sj_ph4", PHASE, 4);
        chk("sj_tb2", TABLE, 2);
        chk("sj_cs", CS, 3'b010);
        chk("sj_gr", GREEN, 3'b011);
        run_to_entry(cyc);
        chk("sj_len4_t2", cyc, 8);
        chk("sj_ph0", PHASE, 0);
        chk("sj_tb0", TABLE, 0);
        SENS = 3'b000;

        // Pedestrian request for light 2, granted only when it turns green
        PUSH = 3'b100;
        step(1);
        PUSH = 3'b000;
        run_to_entry(cyc);
        chk("pd_len0", cyc, 11);
        chk("pd_ph1", PHASE, 1);
        chk("pd_cg1", CG, 0);
        run_to_entry(cyc);
        chk("pd_ph2", PHASE, 2);
        chk("pd_cg2", CG, 3'b100);
        step(1);
        chk("pd_cg2_pulse", CG, 0);
        run_to_entry(cyc);
        chk("pd_ph3", PHASE, 3);
        chk("pd_cg3", CG, 0);

        // Reset mid-phase 3 with a request for light 1 pending
        PUSH = 3'b010;
        step(1);
        PUSH = 3'b000;
        step(2);
        chk("mr_ph3", PHASE, 3);
        #2 reset = 1'b1;
        #1;
        chk("mr_phase", PHASE, 0);
        chk("mr_table", TABLE, 0);
        chk("mr_green", GREEN, 3'b001);
        chk("mr_cs", CS, 0);
        chk("mr_cg", CG, 0);
        #2 reset = 1'b0;
        run_to_entry(cyc);
        chk("mr_len0", cyc, 4);
        chk("mr_ph1", PHASE, 1);
        chk("mr_cg1", CG, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
